// File: rtl/kbd_event_ctrl.sv
// ---------------------------------------------------------------------------
// kbd_event_ctrl
//
// Raw PS/2 keyboard event controller. Decodes PS/2 frames into make/break
// events, tracks up to KEYS held keys, generates typematic repeats for the
// most recently pressed key and queues everything in a small event FIFO.
// Software reads the FIFO through a status/data register pair on the bus.
//
// Ports:
//   clk_sys      - system clock, everything on its rising edge
//   bus_reset_n  - asynchronous active-low reset
//   ce_bus       - tick enable for the repeat timer
//   bus_din      - bus write data
//   bus_dout     - bus read data, 0 when not selected
//   bus_addr     - bus byte address
//   bus_sync     - address phase valid
//   bus_we       - write cycle
//   bus_stb      - data strobe
//   bus_ack      - strobe acknowledge for a selected register
//   virq_req     - interrupt request
//   virq_ack     - interrupt acknowledge (rising edge)
//   ps2_kbd_clk  - raw PS/2 clock
//   ps2_kbd_data - raw PS/2 data
//   key_any      - high while any key is held
//
// Event word: [10] repeat, [9] break, [8] E0 prefix, [7:0] scancode.
// Status:     [7] non-empty, [6] irq disable, [5] overflow, [4] error,
//             [3:0] count.
// ---------------------------------------------------------------------------
module kbd_event_ctrl #(
    parameter logic [15:0] BASE_ADDR  = 16'o177720,
    parameter int          FIFO_DEPTH = 8,
    parameter int          KEYS       = 6,
    parameter int          REP_DELAY  = 250,
    parameter int          REP_RATE   = 40,
    parameter int          RX_TIMEOUT = 4096
) (
    input  logic        clk_sys,
    input  logic        bus_reset_n,
    input  logic        ce_bus,
    input  logic [15:0] bus_din,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_addr,
    input  logic        bus_sync,
    input  logic        bus_we,
    input  logic        bus_stb,
    output logic        bus_ack,
    output logic        virq_req,
    input  logic        virq_ack,
    input  logic        ps2_kbd_clk,
    input  logic        ps2_kbd_data,
    output logic        key_any
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam int RW = $clog2(((REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE) + 1);
    localparam logic [15:0] DATA_ADDR = BASE_ADDR + 16'd2;

    typedef enum logic [1:0] {RX_START, RX_BITS, RX_STOP} rx_state_e;

    logic            ps2ClkMeta_q, ps2DataMeta_q, ps2Data_q;
    logic [2:0]      ps2ClkSh_q;
    rx_state_e       rxState_q, rxState_d;
    logic [3:0]      bitCnt_q, bitCnt_d;
    logic [8:0]      shift_q, shift_d;
    logic [TW-1:0]   idleCnt_q, idleCnt_d;
    logic            e0_q, e0_d, brk_q, brk_d;
    logic [KEYS-1:0] keyValid_q, keyValid_d;
    logic [8:0]      keyId_q [KEYS];
    logic [8:0]      keyId_d [KEYS];
    logic            repValid_q, repValid_d, repFirst_q, repFirst_d;
    logic            repPending_q, repPending_d;
    logic [8:0]      repKey_q, repKey_d;
    logic [RW-1:0]   repCnt_q, repCnt_d, repThresh;
    logic [10:0]     fifo_q [FIFO_DEPTH];
    logic [PW-1:0]   wrPtr_q, rdPtr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            irqDis_q, irqDis_d, ovf_q, ovf_d, err_q, err_d;
    logic            irq_q, irq_d, stbSel_q, ackPrev_q;
    logic [15:0]     dout_q, dout_d, statusVal;

    logic        ps2Fall, byteValid, rxErr, rxEvt, evtBrk, hit, doInsert, insertDone;
    logic        repDue, pushReq, pushDo, popDo;
    logic [8:0]  evtKey;
    logic [10:0] pushData;
    logic        selStat, selData, stbRise, dataRd, statWr, statRd;
    logic        unusedBits;

    assign unusedBits = ^{bus_din[15:7], bus_din[3:0], bus_addr[0]};

    // The synchronised clock must be seen high twice and then low, which
    // filters single-sample glitches on the slow PS/2 line.
    assign ps2Fall = ps2ClkSh_q[2] & ps2ClkSh_q[1] & ~ps2ClkSh_q[0];

    // Data-register writes are deliberately left unselected so they get no ack.
    assign selStat = bus_sync && (bus_addr[15:1] == BASE_ADDR[15:1]);
    assign selData = bus_sync && (bus_addr[15:1] == DATA_ADDR[15:1]) && !bus_we;
    assign stbRise = bus_stb && (selStat || selData) && !stbSel_q;
    assign dataRd  = stbRise && selData;
    assign statWr  = stbRise && selStat && bus_we;
    assign statRd  = stbRise && selStat && !bus_we;
    assign popDo   = dataRd && (count_q != '0);
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign pushDo  = pushReq && ((count_q != CW'(FIFO_DEPTH)) || popDo);

    assign statusVal = {8'h00, count_q != '0, irqDis_q, ovf_q, err_q, 4'(count_q)};
    assign bus_ack   = bus_stb && (selStat || selData);
    assign bus_dout  = (selStat || selData) ? dout_q : 16'h0000;
    assign virq_req  = irq_q;
    assign key_any   = |keyValid_q;

    // PS/2 frame receiver: start bit, nine data/parity bits shifted LSB
    // first into the top of shift_q, then stop bit with the parity check.
    // A frame that stalls for RX_TIMEOUT cycles is dropped without error.
    always_comb begin
        rxState_d = rxState_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        idleCnt_d = '0;
        byteValid = 1'b0;
        rxErr     = 1'b0;
        case (rxState_q)
            RX_START: if (ps2Fall) begin
                if (!ps2Data_q) begin
                    rxState_d = RX_BITS;
                    bitCnt_d  = '0;
                end else begin
                    rxErr = 1'b1;
                end
            end
            RX_BITS: if (ps2Fall) begin
                shift_d  = {ps2Data_q, shift_q[8:1]};
                bitCnt_d = bitCnt_q + 1'b1;
                if (bitCnt_q == 4'd8) rxState_d = RX_STOP;
            end
            RX_STOP: if (ps2Fall) begin
                rxState_d = RX_START;
                if (ps2Data_q && (^shift_q)) byteValid = 1'b1;
                else                         rxErr     = 1'b1;
            end
            default: rxState_d = RX_START;
        endcase
        if (rxState_q != RX_START && !ps2Fall) begin
            if (idleCnt_q == TW'(RX_TIMEOUT - 1)) rxState_d = RX_START;
            else                                  idleCnt_d = idleCnt_q + 1'b1;
        end
    end

    // Prefix bytes only arm flags; any other byte becomes an event and
    // consumes both flags.
    always_comb begin
        e0_d   = e0_q;
        brk_d  = brk_q;
        rxEvt  = 1'b0;
        evtBrk = 1'b0;
        evtKey = '0;
        if (byteValid) begin
            if (shift_q[7:0] == 8'hE0) begin
                e0_d = 1'b1;
            end else if (shift_q[7:0] == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                rxEvt  = 1'b1;
                evtBrk = brk_q;
                evtKey = {e0_q, shift_q[7:0]};
                e0_d   = 1'b0;
                brk_d  = 1'b0;
            end
        end
    end

    // Held-key table and typematic repeat. A repeat that collides with a
    // received event stays pending and goes out on the next free cycle.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < KEYS; i++)
            if (keyValid_q[i] && keyId_q[i] == evtKey) hit = 1'b1;
        doInsert   = rxEvt && !evtBrk && !hit && !(&keyValid_q);
        keyValid_d = keyValid_q;
        keyId_d    = keyId_q;
        insertDone = 1'b0;
        for (int i = 0; i < KEYS; i++) begin
            if (rxEvt && evtBrk && keyValid_q[i] && keyId_q[i] == evtKey)
                keyValid_d[i] = 1'b0;
            if (doInsert && !keyValid_q[i] && !insertDone) begin
                keyValid_d[i] = 1'b1;
                keyId_d[i]    = evtKey;
                insertDone    = 1'b1;
            end
        end

        repValid_d = repValid_q;
        repKey_d   = repKey_q;
        repFirst_d = repFirst_q;
        repCnt_d   = repCnt_q;
        repThresh  = repFirst_q ? RW'(REP_DELAY) : RW'(REP_RATE);
        repDue     = repValid_q && ce_bus && (repCnt_q + 1'b1 == repThresh);
        if (repValid_q && ce_bus) begin
            if (repDue) begin
                repCnt_d   = '0;
                repFirst_d = 1'b0;
            end else begin
                repCnt_d = repCnt_q + 1'b1;
            end
        end
        repPending_d = repPending_q | repDue;

        pushReq  = 1'b0;
        pushData = '0;
        if (rxEvt) begin
            if (evtBrk) begin
                pushReq  = 1'b1;
                pushData = {2'b01, evtKey};
                if (repValid_q && repKey_q == evtKey) begin
                    repValid_d   = 1'b0;
                    repPending_d = 1'b0;
                end
            end else if (!hit) begin
                pushReq  = 1'b1;
                pushData = {2'b00, evtKey};
                if (doInsert) begin
                    repValid_d   = 1'b1;
                    repKey_d     = evtKey;
                    repCnt_d     = '0;
                    repFirst_d   = 1'b1;
                    repPending_d = 1'b0;
                end
            end
        end else if (repPending_d) begin
            pushReq      = 1'b1;
            pushData     = {2'b10, repKey_q};
            repPending_d = 1'b0;
        end
    end

    // Status flags, interrupt and read data. Clears are applied after sets
    // so a clear always wins over a simultaneous set.
    always_comb begin
        count_d  = count_q;
        irqDis_d = irqDis_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        irq_d    = irq_q;
        dout_d   = dout_q;
        if (pushDo && !popDo)      count_d = count_q + 1'b1;
        else if (!pushDo && popDo) count_d = count_q - 1'b1;
        if (pushReq && !pushDo) ovf_d = 1'b1;
        if (rxErr)              err_d = 1'b1;
        if (pushReq && !irqDis_q) irq_d = 1'b1;
        if (statWr) begin
            irqDis_d = bus_din[6];
            if (bus_din[5]) ovf_d = 1'b0;
            if (bus_din[4]) err_d = 1'b0;
        end
        if ((virq_ack && !ackPrev_q) || dataRd || (statWr && bus_din[6])) irq_d = 1'b0;
        if (statRd) dout_d = statusVal;
        if (dataRd) dout_d = popDo ? {5'b00000, fifo_q[rdPtr_q]} : 16'h0000;
    end

    // State registers; reset puts everything back to idle immediately.
    always_ff @(posedge clk_sys or negedge bus_reset_n) begin
        if (!bus_reset_n) begin
            ps2ClkMeta_q  <= 1'b1;
            ps2ClkSh_q    <= 3'b111;
            ps2DataMeta_q <= 1'b1;
            ps2Data_q     <= 1'b1;
            rxState_q     <= RX_START;
            bitCnt_q      <= '0;
            shift_q       <= '0;
            idleCnt_q     <= '0;
            e0_q          <= 1'b0;
            brk_q         <= 1'b0;
            keyValid_q    <= '0;
            for (int i = 0; i < KEYS; i++) keyId_q[i] <= '0;
            repValid_q    <= 1'b0;
            repKey_q      <= '0;
            repFirst_q    <= 1'b1;
            repCnt_q      <= '0;
            repPending_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            irqDis_q      <= 1'b1;
            ovf_q         <= 1'b0;
            err_q         <= 1'b0;
            irq_q         <= 1'b0;
            dout_q        <= '0;
            stbSel_q      <= 1'b0;
            ackPrev_q     <= 1'b0;
        end else begin
            ps2ClkMeta_q  <= ps2_kbd_clk;
            ps2ClkSh_q    <= {ps2ClkSh_q[1:0], ps2ClkMeta_q};
            ps2DataMeta_q <= ps2_kbd_data;
            ps2Data_q     <= ps2DataMeta_q;
            rxState_q     <= rxState_d;
            bitCnt_q      <= bitCnt_d;
            shift_q       <= shift_d;
            idleCnt_q     <= idleCnt_d;
            e0_q          <= e0_d;
            brk_q         <= brk_d;
            keyValid_q    <= keyValid_d;
            keyId_q       <= keyId_d;
            repValid_q    <= repValid_d;
            repKey_q      <= repKey_d;
            repFirst_q    <= repFirst_d;
            repCnt_q      <= repCnt_d;
            repPending_q  <= repPending_d;
            if (pushDo) begin
                fifo_q[wrPtr_q] <= pushData;
                wrPtr_q         <= wrPtr_q + 1'b1;
            end
            if (popDo) rdPtr_q <= rdPtr_q + 1'b1;
            count_q       <= count_d;
            irqDis_q      <= irqDis_d;
            ovf_q         <= ovf_d;
            err_q         <= err_d;
            irq_q         <= irq_d;
            dout_q        <= dout_d;
            stbSel_q      <= bus_stb && (selStat || selData);
            ackPrev_q     <= virq_ack;
        end
    end
endmodule
